// File: rtl/m_layer_output_0.sv
// Output-layer capture: buffers one frame of NUM_OUT signed samples, tracks the
// arg-max while they stream in, and exposes the buffer through a 1-cycle read port.
module m_layer_output_0 #(
  parameter int NUM_OUT = 10,
  parameter int ADDR_W  = 4
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [15:0]       map_in,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [15:0]       rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] class_out,
  output logic [15:0]       max_out
);

  if ((2 ** ADDR_W) < NUM_OUT) begin : g_addr_chk
    $error("ADDR_W too narrow for NUM_OUT");
  end

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_class;
  logic [15:0]       r_max;
  logic [15:0]       r_rd_data;
  logic [15:0]       r_mem [NUM_OUT];

  logic w_wr, w_last, w_enter, w_take;

  // An abort (start low) wins over a coincident valid sample: nothing is written.
  assign w_wr    = (r_state == S_CAPTURE) && start && in_valid;
  assign w_last  = (r_wr_addr == ADDR_W'(NUM_OUT - 1));
  assign w_enter = (r_state == S_IDLE) && start;
  assign w_take  = (r_wr_addr == '0) || ($signed(map_in) > $signed(r_max));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        if (!start)                w_state_nxt = S_IDLE;
        else if (in_valid && w_last) w_state_nxt = S_DONE;
      end
      S_DONE:    if (!start) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_addr <= '0;
      r_class   <= '0;
      r_max     <= '0;
    end else if (w_enter) begin
      r_wr_addr <= '0;
      r_class   <= '0;
      r_max     <= '0;
    end else if (w_wr) begin
      if (!w_last) r_wr_addr <= r_wr_addr + 1'b1;
      // Strict '>' so a tie keeps the earlier index.
      if (w_take) begin
        r_max   <= map_in;
        r_class <= r_wr_addr;
      end
    end
  end

  // Storage carries no reset so it maps onto RAM primitives.
  always_ff @(posedge clk_in) begin
    if (w_wr) r_mem[r_wr_addr] <= map_in;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) r_rd_data <= '0;
    else        r_rd_data <= r_mem[rd_addr];
  end

  assign rd_data   = r_rd_data;
  assign busy      = (r_state == S_CAPTURE);
  assign done      = (r_state == S_DONE);
  assign class_out = r_class;
  assign max_out   = r_max;

endmodule

// File: tb/tb_m_layer_output_0.sv
// Directed bench for m_layer_output_0: table of frames with hand-computed
// arg-max results, plus reset/abort/read-before-write sequences.
module tb_m_layer_output_0;

  localparam int N  = 10;
  localparam int AW = 4;

  logic          clk_in = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic [15:0]   map_in;
  logic [AW-1:0] rd_addr;
  logic [15:0]   rd_data;
  logic          busy, done;
  logic [AW-1:0] class_out;
  logic [15:0]   max_out;

  m_layer_output_0 #(.NUM_OUT(N), .ADDR_W(AW)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .map_in(map_in), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
    .done(done), .class_out(class_out), .max_out(max_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [N-1:0][15:0] d;
    bit                 gap;
    logic [AW-1:0]      cls;
    logic [15:0]        mx;
  } vec_t;

  vec_t        vt [5];
  logic [15:0] mm [N];
  bit          mk [N];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic begin_frame();
    @(negedge clk_in);
    start = 1'b1; in_valid = 1'b0;
    @(negedge clk_in);
    chk("busy_on_start", 32'(busy), 32'd1);
  endtask

  // Drives one valid sample at address k; the read port watches the same
  // address so the next negedge must show the pre-write contents.
  task automatic send(input int k, input logic [15:0] v);
    chk($sformatf("busy_s%0d", k), 32'(busy), 32'd1);
    chk($sformatf("done_lo_s%0d", k), 32'(done), 32'd0);
    rd_addr = AW'(k); in_valid = 1'b1; map_in = v;
    @(negedge clk_in);
    if (mk[k]) chk($sformatf("rbw_a%0d", k), 32'(rd_data), 32'(mm[k]));
    mm[k] = v; mk[k] = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic end_frame(input int i);
    chk($sformatf("v%0d_done", i), 32'(done), 32'd1);
    chk($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
    chk($sformatf("v%0d_class", i), 32'(class_out), 32'(vt[i].cls));
    chk($sformatf("v%0d_max", i), 32'(max_out), 32'(vt[i].mx));
    // in_valid in DONE must not disturb anything
    in_valid = 1'b1; map_in = 16'h7FFF;
    @(negedge clk_in);
    in_valid = 1'b0;
    chk($sformatf("v%0d_hold_max", i), 32'(max_out), 32'(vt[i].mx));
    for (int k = 0; k < N; k++) begin
      rd_addr = AW'(k);
      @(negedge clk_in);
      chk($sformatf("v%0d_rd%0d", i, k), 32'(rd_data), 32'(vt[i].d[k]));
    end
    start = 1'b0;
    @(negedge clk_in);
    chk($sformatf("v%0d_idle_done", i), 32'(done), 32'd0);
    chk($sformatf("v%0d_idle_class", i), 32'(class_out), 32'(vt[i].cls));
    chk($sformatf("v%0d_idle_max", i), 32'(max_out), 32'(vt[i].mx));
  endtask

  task automatic run_vec(input int i);
    begin_frame();
    for (int k = 0; k < N; k++) begin
      send(k, vt[i].d[k]);
      if (vt[i].gap && k < N - 1) begin
        @(negedge clk_in);
        chk($sformatf("v%0d_gap%0d_done", i, k), 32'(done), 32'd0);
      end
    end
    end_frame(i);
  endtask

  initial begin
    int a0 [N] = '{0, -5, 3, 100, 2, -1, 0, 200, 7, 9};
    int a4 [N] = '{1, 2, 5, 0, 0, 0, 5, 0, 0, 0};
    for (int k = 0; k < N; k++) begin
      vt[0].d[k] = 16'(a0[k]);
      vt[1].d[k] = 16'(a0[k]);
      vt[2].d[k] = 16'hFFFD;
      vt[3].d[k] = 16'(-32768 + k);
      vt[4].d[k] = 16'(a4[k]);
      mk[k] = 1'b0;
    end
    vt[0].gap = 0; vt[0].cls = 4'd7; vt[0].mx = 16'd200;
    vt[1].gap = 1; vt[1].cls = 4'd7; vt[1].mx = 16'd200;
    vt[2].gap = 0; vt[2].cls = 4'd0; vt[2].mx = 16'hFFFD;
    vt[3].gap = 0; vt[3].cls = 4'd9; vt[3].mx = 16'h8009;
    vt[4].gap = 1; vt[4].cls = 4'd2; vt[4].mx = 16'd5;

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; map_in = '0; rd_addr = '0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_class", 32'(class_out), 32'd0);
    chk("rst_max", 32'(max_out), 32'd0);
    chk("rst_rd", 32'(rd_data), 32'd0);
    @(negedge clk_in); @(negedge clk_in);
    rst_n = 1'b1;
    @(negedge clk_in); @(negedge clk_in);
    chk("wait_start_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 5; i++) run_vec(i);

    // Reset mid-capture, checked before any further clock edge
    begin_frame();
    for (int k = 0; k < 4; k++) send(k, 16'(k * 11 + 1));
    #2 rst_n = 1'b0; start = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_class", 32'(class_out), 32'd0);
    chk("arst_max", 32'(max_out), 32'd0);
    chk("arst_rd", 32'(rd_data), 32'd0);
    @(negedge clk_in);
    rst_n = 1'b1;
    @(negedge clk_in);
    chk("post_rst_idle", 32'(busy), 32'd0);
    run_vec(0);

    // Abort after 5 samples, then a full frame from address 0
    begin_frame();
    for (int k = 0; k < 5; k++) send(k, vt[4].d[k]);
    start = 1'b0;
    @(negedge clk_in);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk_in);
    chk("abort_done2", 32'(done), 32'd0);
    run_vec(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
